// File: rtl/readout_merge_arb.sv
// Merges CHANNELS first-word-fall-through FIFOs onto one valid/ready output stream using bursty grants.
// Optional per-channel transferred-word counters are built only when READOUT_ARB_WORD_COUNT_EN is defined.
module readout_merge_arb #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 16
) (
    input  logic                           BUS_CLK,
    input  logic                           BUS_RST,
    input  logic [CHANNELS-1:0]            CH_EMPTY,
    input  logic [CHANNELS*DATA_WIDTH-1:0] CH_DATA,
    output logic [CHANNELS-1:0]            CH_READ,
    input  logic [CHANNELS-1:0]            CH_HOLD,
    input  logic [CHANNELS-1:0]            CH_ENABLE,
    input  logic                           MODE,
    output logic                           OUT_VALID,
    input  logic                           OUT_READY,
    output logic [DATA_WIDTH-1:0]          OUT_DATA,
    output logic [3:0]                     OUT_CHANNEL,
    output logic [CHANNELS*16-1:0]         WORD_COUNT,
    output logic                           dbg_state,
    output logic [7:0]                     dbg_bcnt
);

    localparam int         GW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   grant, grant_nxt;
    logic [GW-1:0]   last, last_nxt;
    logic [7:0]      bcnt, bcnt_nxt;

    logic [CHANNELS-1:0]   req;
    logic [CHANNELS-1:0]   gsel;
    logic                  req_g;
    logic                  hold_g;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  fp_found;
    logic [GW-1:0]         fp_pick;
    logic                  up_found;
    logic [GW-1:0]         up_pick;
    logic                  out_free;
    logic                  pop;

    assign req = ~CH_EMPTY & CH_ENABLE;

    // Grant decoded one-hot so the muxes never index with an oversized grant value.
    always_comb begin
        gsel     = '0;
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == GW'(i)) begin
                gsel[i]  = 1'b1;
                sel_data = CH_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign req_g  = |(req & gsel);
    assign hold_g = |(CH_HOLD & gsel);

    // Descending scan leaves the lowest matching index; the "above last" pick
    // falling back to the overall lowest gives round-robin with wrap to 0.
    always_comb begin
        fp_found = 1'b0;
        fp_pick  = '0;
        up_found = 1'b0;
        up_pick  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[i]) begin
                fp_found = 1'b1;
                fp_pick  = GW'(i);
            end
            if (req[i] && (GW'(i) > last)) begin
                up_found = 1'b1;
                up_pick  = GW'(i);
            end
        end
    end

    // Output handshake: a word transfers on a rising edge where OUT_VALID and
    // OUT_READY are both high; while OUT_VALID is high and OUT_READY low the
    // word and channel are held, and a new pop happens only into a free register.
    assign out_free = ~OUT_VALID | OUT_READY;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        bcnt_nxt  = bcnt;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fp_found) begin
                    grant_nxt = MODE ? fp_pick : (up_found ? up_pick : fp_pick);
                    bcnt_nxt  = 8'd0;
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                pop = out_free & req_g;
                if (pop && (bcnt != 8'hFF)) begin
                    bcnt_nxt = bcnt + 8'd1;
                end
                // Hold suspends the length limit; once hold drops an over-limit count exits at once.
                if (!req_g || (!hold_g && (bcnt_nxt >= BURST_LIM))) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = grant;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state <= ST_IDLE;
            grant <= '0;
            last  <= GW'(CHANNELS - 1);
            bcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    assign CH_READ = BUS_RST ? '0 : (gsel & {CHANNELS{pop}});

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            OUT_VALID   <= 1'b0;
            OUT_DATA    <= '0;
            OUT_CHANNEL <= 4'd0;
        end else if (out_free) begin
            OUT_VALID <= pop;
            if (pop) begin
                OUT_DATA    <= sel_data;
                OUT_CHANNEL <= 4'(grant);
            end
        end
    end

`ifdef READOUT_ARB_WORD_COUNT_EN
    for (genvar i = 0; i < CHANNELS; i++) begin : g_wcnt
        logic [15:0] cnt;
        always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
            if (BUS_RST) begin
                cnt <= 16'd0;
            end else if (CH_READ[i] && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign WORD_COUNT[i*16 +: 16] = cnt;
    end
`else
    assign WORD_COUNT = '0;
`endif

    assign dbg_state = (state == ST_BURST);
    assign dbg_bcnt  = bcnt;

endmodule

// File: tb/tb_readout_merge_arb.sv
// Directed bench for readout_merge_arb (CHANNELS=4, BURST_MAX=4): counting FIFO sources,
// expected words queued at stimulus time, and a monitor that checks every accepted output word.
`timescale 1ns/1ps
module tb_readout_merge_arb;

    localparam int CH = 4;
    localparam int DW = 32;
    localparam int BM = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [CH-1:0]    ch_empty, ch_read, ch_hold, ch_enable;
    logic [CH*DW-1:0] ch_data;
    logic             mode, out_valid, out_ready;
    logic [DW-1:0]    out_data;
    logic [3:0]       out_channel;
    logic [CH*16-1:0] word_count;
    logic             dbg_state;
    logic [7:0]       dbg_bcnt;

    readout_merge_arb #(
        .CHANNELS  (CH),
        .DATA_WIDTH(DW),
        .BURST_MAX (BM)
    ) dut (
        .BUS_CLK    (clk),
        .BUS_RST    (rst),
        .CH_EMPTY   (ch_empty),
        .CH_DATA    (ch_data),
        .CH_READ    (ch_read),
        .CH_HOLD    (ch_hold),
        .CH_ENABLE  (ch_enable),
        .MODE       (mode),
        .OUT_VALID  (out_valid),
        .OUT_READY  (out_ready),
        .OUT_DATA   (out_data),
        .OUT_CHANNEL(out_channel),
        .WORD_COUNT (word_count),
        .dbg_state  (dbg_state),
        .dbg_bcnt   (dbg_bcnt)
    );

    // ---------------- source model and scoreboard state ----------------
    int          src_left[CH];
    int          src_idx[CH];
    logic [7:0]  src_tag[CH];
    logic [CH-1:0] rd_s;

    logic [39:0] exp_q[$];   // {expected gap in cycles (0 = any), channel, data}
    logic [39:0] e;
    int          errors = 0;
    int          checks = 0;
    int          accepted = 0;
    bit          sb_bypass = 1'b0;
    int          cyc = 0;
    int          last_acc = 0;

    function automatic logic [31:0] word_of(int ch, logic [7:0] tag, int idx);
        return {8'(ch), tag, 16'(idx)};
    endfunction

    task automatic drive_src();
        for (int i = 0; i < CH; i++) begin
            ch_empty[i]          = (src_left[i] == 0);
            ch_data[i*DW +: DW]  = word_of(i, src_tag[i], src_idx[i]);
        end
    endtask

    function automatic bit src_all_empty();
        for (int i = 0; i < CH; i++) if (src_left[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Pops are sampled just before the edge and applied just after it.
    always begin
        @(negedge clk);
        #4;
        rd_s = ch_read;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < CH; i++) begin
            if (rd_s[i] && src_left[i] > 0) begin
                src_left[i]--;
                src_idx[i]++;
            end
        end
        drive_src();
    end

    // ---------------- monitor ----------------
    always begin
        @(negedge clk);
        #4;
        if (!rst) begin
            checks += 3;
            if ((ch_read & (ch_read - 1'b1)) != '0) begin
                errors++;
                $display("FAIL rd_onehot got=%b required=at most one bit", ch_read);
            end
            if (ch_read != '0 && out_valid && !out_ready) begin
                errors++;
                $display("FAIL rd_stall got=%b required=0 while output stalled", ch_read);
            end
            if ((ch_read & ch_empty) != '0) begin
                errors++;
                $display("FAIL rd_empty got=%b empty=%b", ch_read, ch_empty);
            end
            if (out_valid && out_ready) begin
                accepted++;
                if (!sb_bypass) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra got=%h/%h required=no word", out_channel, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_channel, out_data} !== e[35:0]) begin
                            errors++;
                            $display("FAIL sb_word got=%h/%h required=%h/%h",
                                     out_channel, out_data, e[35:32], e[31:0]);
                        end
                        if (e[39:36] != 4'd0) begin
                            checks++;
                            if (cyc - last_acc != int'(e[39:36])) begin
                                errors++;
                                $display("FAIL sb_gap ch=%0d got=%0d required=%0d",
                                         out_channel, cyc - last_acc, e[39:36]);
                            end
                        end
                    end
                end
                last_acc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(string name, logic [63:0] got, logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic load(int ch, int n, logic [7:0] tag);
        src_left[ch] = n;
        src_idx[ch]  = 0;
        src_tag[ch]  = tag;
    endtask

    task automatic expect_words(int ch, logic [7:0] tag, int from, int n, int first_gap, int inner_gap);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({4'((k == 0) ? first_gap : inner_gap), 4'(ch), word_of(ch, tag, from + k)});
        end
    endtask

    task automatic wait_drain(string name, int max_cycles);
        int n = 0;
        while (n < max_cycles &&
               !(exp_q.size() == 0 && src_all_empty() && !out_valid && !dbg_state)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= max_cycles) begin
            errors++;
            $display("FAIL %s_timeout got=%0d left required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst       = 1'b1;
        ch_hold   = '0;
        ch_enable = '1;
        mode      = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < CH; i++) load(i, 0, 8'h00);
        drive_src();
        repeat (3) @(negedge clk);

        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_out_data",    64'(out_data),    64'd0);
        check("rst_out_channel", 64'(out_channel), 64'd0);
        check("rst_word_count",  word_count,       64'd0);
        check("rst_state",       64'(dbg_state),   64'd0);
        check("rst_ch_read",     64'(ch_read),     64'd0);
        check("rst_bcnt",        64'(dbg_bcnt),    64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Round-robin, four channels of six words, limit exits cost one bubble.
        for (int i = 0; i < CH; i++) load(i, 6, 8'hA0);
        drive_src();
        expect_words(0, 8'hA0, 0, 4, 0, 1);
        expect_words(1, 8'hA0, 0, 4, 2, 1);
        expect_words(2, 8'hA0, 0, 4, 2, 1);
        expect_words(3, 8'hA0, 0, 4, 2, 1);
        expect_words(0, 8'hA0, 4, 2, 2, 1);
        expect_words(1, 8'hA0, 4, 2, 3, 1);
        expect_words(2, 8'hA0, 4, 2, 3, 1);
        expect_words(3, 8'hA0, 4, 2, 3, 1);
        wait_drain("rr", 300);

        // Fixed priority: ch1 drains completely before ch3 is served.
        mode = 1'b1;
        load(1, 10, 8'hB0);
        load(3, 10, 8'hB0);
        drive_src();
        expect_words(1, 8'hB0, 0, 4, 0, 1);
        expect_words(1, 8'hB0, 4, 4, 2, 1);
        expect_words(1, 8'hB0, 8, 2, 2, 1);
        expect_words(3, 8'hB0, 0, 4, 3, 1);
        expect_words(3, 8'hB0, 4, 4, 2, 1);
        expect_words(3, 8'hB0, 8, 2, 2, 1);
        wait_drain("fp", 300);
        mode = 1'b0;

        // Hold stretches one burst over all nine words.
        ch_hold[2] = 1'b1;
        load(2, 9, 8'hC0);
        drive_src();
        expect_words(2, 8'hC0, 0, 9, 0, 1);
        wait_drain("hold", 200);
        check("hold_bcnt",  64'(dbg_bcnt),  64'd9);
        check("hold_state", 64'(dbg_state), 64'd0);
        ch_hold = '0;

        // Random backpressure on a 100-word channel.
        load(0, 100, 8'hD0);
        drive_src();
        expect_words(0, 8'hD0, 0, 100, 0, 0);
        for (int c = 0; c < 600; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_drain("bp", 300);

        // Reset while a stalled word sits in the output register.
        out_ready = 1'b0;
        load(2, 8, 8'hE0);
        drive_src();
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid", 64'(out_valid), 64'd1);
        load(0, 3, 8'hE1);
        drive_src();
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_ch_read",   64'(ch_read),   64'd0);
        check("arst_state",     64'(dbg_state), 64'd0);
        exp_q.delete();
        expect_words(0, 8'hE1, 0, 3, 0, 1);
        expect_words(2, 8'hE0, 1, 4, 3, 1);
        expect_words(2, 8'hE0, 5, 3, 2, 1);
        @(negedge clk);
        #3;
        check("arst_ch_read_hold", 64'(ch_read), 64'd0);
        out_ready = 1'b1;
        rst = 1'b0;
        wait_drain("rst", 200);
`ifdef READOUT_ARB_WORD_COUNT_EN
        check("word_count_after_rst", word_count, {16'd0, 16'd7, 16'd0, 16'd3});

        // Long held burst saturates the ch3 counter only.
        pulse_reset();
        ch_hold[3] = 1'b1;
        sb_bypass  = 1'b1;
        accepted   = 0;
        load(3, 70000, 8'hF0);
        drive_src();
        wait_drain("bulk", 80000);
        check("bulk_accepted", 64'(accepted), 64'd70000);
        check("bulk_word_count", word_count, {16'hFFFF, 48'd0});
        sb_bypass = 1'b0;
        ch_hold   = '0;
`else
        check("word_count_off", word_count, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog got=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
